// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised raster timing generator with pixel divider, strobes and frame counter
// Counters, syncs and blanking share one register stage so every output moves on the same pix_ce edge.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int CLK_DIV    = 2,
  parameter int CNT_W      = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             resync,
  output logic             pix_ce,
  output logic             vga_clk,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic             VGA_BLANK_N,
  output logic             VGA_SYNC_N,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             HS_ON    = (H_SYNC_POL != 0);
  localparam logic             VS_ON    = (V_SYNC_POL != 0);

  logic [DIV_W-1:0] r_div_cnt;
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             r_vga_clk;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_active;
  logic             r_line_start;
  logic             r_frame_start;
  logic [7:0]       r_frame_cnt;

  logic             w_pix_ce;
  logic [DIV_W-1:0] w_div_nxt;
  logic             w_vga_rise;
  logic             w_x_wrap;
  logic             w_y_wrap;
  logic [CNT_W-1:0] w_x_nxt;
  logic [CNT_W-1:0] w_y_nxt;
  logic             w_hs_in;
  logic             w_vs_in;
  logic             w_act_nxt;

  always_comb begin
    w_pix_ce  = en && (r_div_cnt == DIV_LAST);
    w_div_nxt = (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DIV_W'(1);
    w_x_wrap  = (r_x == H_LAST);
    w_y_wrap  = (r_y == V_LAST);
    w_x_nxt   = r_x;
    w_y_nxt   = r_y;
    if (resync) begin
      w_x_nxt = '0;
      w_y_nxt = '0;
    end else if (w_pix_ce) begin
      w_x_nxt = w_x_wrap ? '0 : r_x + CNT_W'(1);
      if (w_x_wrap)
        w_y_nxt = w_y_wrap ? '0 : r_y + CNT_W'(1);
    end
    w_hs_in   = (w_x_nxt >= HS_BEG) && (w_x_nxt < HS_END);
    w_vs_in   = (w_y_nxt >= VS_BEG) && (w_y_nxt < VS_END);
    w_act_nxt = (w_x_nxt < H_ACT) && (w_y_nxt < V_ACT);
  end

  // vga_clk low for the first half of each pixel, so it falls on the advancing edge
  generate
    if (CLK_DIV > 1) begin : g_div
      localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
      assign w_vga_rise = (w_div_nxt >= DIV_HALF);
    end else begin : g_nodiv
      assign w_vga_rise = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt     <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_vga_clk     <= 1'b0;
      r_hsync       <= ~HS_ON;
      r_vsync       <= ~VS_ON;
      r_active      <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_hsync       <= w_hs_in ? HS_ON : ~HS_ON;
      r_vsync       <= w_vs_in ? VS_ON : ~VS_ON;
      r_active      <= w_act_nxt;
      r_line_start  <= !resync && w_pix_ce && w_x_wrap;
      r_frame_start <= !resync && w_pix_ce && w_x_wrap && w_y_wrap;
      if (resync) begin
        r_div_cnt <= '0;
        r_vga_clk <= 1'b0;
      end else if (en) begin
        r_div_cnt <= w_div_nxt;
        r_vga_clk <= w_vga_rise;
        if (w_pix_ce && w_x_wrap && w_y_wrap)
          r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign pix_ce      = w_pix_ce;
  assign vga_clk     = r_vga_clk;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign active      = r_active;
  assign VGA_BLANK_N = r_active;
  assign VGA_SYNC_N  = 1'b1;
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen over three geometries
// The reference model tracks enabled clock ticks since restart and derives every output arithmetically.
module tb_vga_timing_gen;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic resync;

  logic [N-1:0] pix_ce_o, vga_clk_o, hsync_o, vsync_o, active_o, blank_n_o, sync_n_o;
  logic [N-1:0] line_start_o, frame_start_o;
  logic [10:0]  x_o [N];
  logic [10:0]  y_o [N];
  logic [7:0]   fc_o [N];

  always #5 clk = ~clk;

  // geometry 0: 4/1/2/1 x 3/1/1/1, div 3, active-high syncs
  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .H_SYNC_POL(1), .V_SYNC_POL(1), .CLK_DIV(3), .CNT_W(11)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .resync(resync), .pix_ce(pix_ce_o[0]), .vga_clk(vga_clk_o[0]),
    .hsync(hsync_o[0]), .vsync(vsync_o[0]), .active(active_o[0]), .VGA_BLANK_N(blank_n_o[0]),
    .VGA_SYNC_N(sync_n_o[0]), .x(x_o[0]), .y(y_o[0]), .line_start(line_start_o[0]),
    .frame_start(frame_start_o[0]), .frame_cnt(fc_o[0]));

  vga_timing_gen #(.H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
                   .H_SYNC_POL(0), .V_SYNC_POL(0), .CLK_DIV(2), .CNT_W(11)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .resync(resync), .pix_ce(pix_ce_o[1]), .vga_clk(vga_clk_o[1]),
    .hsync(hsync_o[1]), .vsync(vsync_o[1]), .active(active_o[1]), .VGA_BLANK_N(blank_n_o[1]),
    .VGA_SYNC_N(sync_n_o[1]), .x(x_o[1]), .y(y_o[1]), .line_start(line_start_o[1]),
    .frame_start(frame_start_o[1]), .frame_cnt(fc_o[1]));

  vga_timing_gen #(.H_ACTIVE(5), .H_FP(1), .H_SYNC(1), .H_BP(2), .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .H_SYNC_POL(0), .V_SYNC_POL(1), .CLK_DIV(1), .CNT_W(11)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .resync(resync), .pix_ce(pix_ce_o[2]), .vga_clk(vga_clk_o[2]),
    .hsync(hsync_o[2]), .vsync(vsync_o[2]), .active(active_o[2]), .VGA_BLANK_N(blank_n_o[2]),
    .VGA_SYNC_N(sync_n_o[2]), .x(x_o[2]), .y(y_o[2]), .line_start(line_start_o[2]),
    .frame_start(frame_start_o[2]), .frame_cnt(fc_o[2]));

  int ha[N] = '{4, 10, 5};
  int hf[N] = '{1, 2, 1};
  int hs[N] = '{2, 3, 1};
  int hb[N] = '{1, 2, 2};
  int va[N] = '{3, 6, 2};
  int vf[N] = '{1, 1, 1};
  int vs[N] = '{1, 2, 1};
  int vb[N] = '{1, 2, 1};
  int hp[N] = '{1, 0, 0};
  int vp[N] = '{1, 0, 1};
  int dv[N] = '{3, 2, 1};

  longint m_t[N];
  int     m_fbase[N];
  bit     m_ls[N];
  bit     m_fs[N];

  typedef struct {
    int k;
    bit pce, vck, hs, vs, act, ls, fs;
    int x, y, fc;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s[%0d] t=%0t got=%0d expected=%0d", nm, k, $time, act, exp);
    end
  endtask

  function automatic void model_reset(input int k);
    m_t[k] = 0;
    m_fbase[k] = 0;
    m_ls[k] = 0;
    m_fs[k] = 0;
  endfunction

  function automatic void model_emit(input int k, input bit e_in);
    exp_t   e;
    int     ht, vt;
    longint p;
    ht = ha[k] + hf[k] + hs[k] + hb[k];
    vt = va[k] + vf[k] + vs[k] + vb[k];
    p  = m_t[k] / dv[k];
    e.k   = k;
    e.x   = int'(p % ht);
    e.y   = int'((p / ht) % vt);
    e.fc  = int'((m_fbase[k] + p / (ht * vt)) % 256);
    e.pce = e_in && ((m_t[k] % dv[k]) == dv[k] - 1);
    e.vck = (dv[k] > 1) && ((m_t[k] % dv[k]) >= dv[k] / 2);
    e.hs  = (e.x >= ha[k] + hf[k] && e.x < ha[k] + hf[k] + hs[k]) ? hp[k][0] : !hp[k][0];
    e.vs  = (e.y >= va[k] + vf[k] && e.y < va[k] + vf[k] + vs[k]) ? vp[k][0] : !vp[k][0];
    e.act = (e.x < ha[k]) && (e.y < va[k]);
    e.ls  = m_ls[k];
    e.fs  = m_fs[k];
    sb.push_back(e);
  endfunction

  function automatic void model_advance(input int k, input bit r_in, input bit e_in, input bit s_in);
    int     ht, fr;
    longint p0, p1;
    ht = ha[k] + hf[k] + hs[k] + hb[k];
    fr = ht * (va[k] + vf[k] + vs[k] + vb[k]);
    m_ls[k] = 0;
    m_fs[k] = 0;
    if (!r_in) begin
      model_reset(k);
    end else if (s_in) begin
      m_fbase[k] = int'((m_fbase[k] + (m_t[k] / dv[k]) / fr) % 256);
      m_t[k] = 0;
    end else if (e_in) begin
      p0 = m_t[k] / dv[k];
      m_t[k]++;
      p1 = m_t[k] / dv[k];
      if (p1 != p0) begin
        m_ls[k] = (p1 % ht) == 0;
        m_fs[k] = (p1 % fr) == 0;
      end
    end
  endfunction

  function automatic bit strobes_idle();
    bit idle = 1;
    for (int k = 0; k < N; k++)
      if (m_ls[k] || m_fs[k]) idle = 0;
    return idle;
  endfunction

  // drives the inputs between edges; a low rst takes effect immediately, as the async reset does
  task automatic step(input bit r_in, input bit e_in, input bit s_in);
    @(posedge clk);
    #1;
    rst = r_in;
    en = e_in;
    resync = s_in;
    for (int k = 0; k < N; k++) begin
      if (!r_in) model_reset(k);
      model_emit(k, e_in);
      model_advance(k, r_in, e_in, s_in);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0);
  endtask

  task automatic freeze(input int n);
    while (!strobes_idle()) step(1, 1, 0);
    for (int i = 0; i < n; i++) step(1, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pix_ce", e.k, int'(pix_ce_o[e.k]), int'(e.pce));
        chk("vga_clk", e.k, int'(vga_clk_o[e.k]), int'(e.vck));
        chk("hsync", e.k, int'(hsync_o[e.k]), int'(e.hs));
        chk("vsync", e.k, int'(vsync_o[e.k]), int'(e.vs));
        chk("active", e.k, int'(active_o[e.k]), int'(e.act));
        chk("blank_n", e.k, int'(blank_n_o[e.k]), int'(e.act));
        chk("sync_n", e.k, int'(sync_n_o[e.k]), 1);
        chk("x", e.k, int'(x_o[e.k]), e.x);
        chk("y", e.k, int'(y_o[e.k]), e.y);
        chk("line_start", e.k, int'(line_start_o[e.k]), int'(e.ls));
        chk("frame_start", e.k, int'(frame_start_o[e.k]), int'(e.fs));
        chk("frame_cnt", e.k, int'(fc_o[e.k]), e.fc);
      end
    end
  end

  initial begin : stimulus
    bit r_in, e_in, s_in;
    int rst_hold;
    rst = 1'b0;
    en = 1'b0;
    resync = 1'b0;
    for (int k = 0; k < N; k++) model_reset(k);

    for (int i = 0; i < 3; i++) step(0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 0);
    run(1500);
    freeze(37);
    run(400);
    step(1, 1, 1);
    run(400);
    step(1, 0, 1);
    freeze(5);
    run(300);

    rst_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (rst_hold > 0) begin
        rst_hold--;
        r_in = 0;
      end else begin
        r_in = ($urandom_range(0, 499) != 0);
        if (!r_in) rst_hold = $urandom_range(0, 3);
      end
      e_in = ($urandom_range(0, 9) != 0);
      if (!e_in && !strobes_idle()) e_in = 1;
      s_in = ($urandom_range(0, 199) == 0);
      step(r_in, e_in, s_in);
    end

    run(200);
    step(0, 1, 0);
    step(0, 1, 0);
    run(600);

    @(posedge clk);
    #5;
    chk("sb_drained", 0, sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised raster timing generator that replaces the fixed 640x480 timing block. It derives a pixel clock-enable and a pixel clock from the system clock by an integer divider. Horizontal and vertical timing, sync polarity and divider ratio come from parameters. It also adds run/freeze control, a synchronous frame restart, line/frame strobes and a frame counter for the game logic and sprite engines.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
H_SYNC_POL, 0, asserted level of hsync (0 = active-low)
V_SYNC_POL, 0, asserted level of vsync
CLK_DIV, 2, clk cycles per pixel (>=1)
CNT_W, 11, width of x/y counters; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
en  in  1  run enable; low freezes all timing state
resync  in  1  synchronous restart of frame to (0,0)
pix_ce  out  1  one-clk pixel enable; counters advance on edges where high
vga_clk  out  1  divided pixel clock to DAC
hsync  out  1  horizontal sync, polarity H_SYNC_POL
vsync  out  1  vertical sync, polarity V_SYNC_POL
active  out  1  x<H_ACTIVE and y<V_ACTIVE
VGA_BLANK_N  out  1  equals active
VGA_SYNC_N  out  1  constant 1
x  out  CNT_W  current pixel column, 0..H_TOTAL-1
y  out  CNT_W  current line, 0..V_TOTAL-1
line_start  out  1  one-clk pulse when x becomes 0
frame_start  out  1  one-clk pulse when (x,y) becomes (0,0)
frame_cnt  out  8  frames completed, wraps 255->0

Behaviour:
- Totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL likewise (default 525).
- Divider: div_cnt counts 0..CLK_DIV-1 on every clk with en=1. pix_ce = en && div_cnt==CLK_DIV-1; it is combinational from registers. For CLK_DIV=1, pix_ce=en.
- vga_clk is registered: 0 while div_cnt<CLK_DIV/2, 1 otherwise. So it falls on the edge where the counters advance and rises mid-pixel. For CLK_DIV=1, vga_clk is held 0.
- On an edge with pix_ce=1:
  - If x==H_TOTAL-1, x->0 and y advances; y==V_TOTAL-1 wraps to 0.
  - Otherwise x->x+1 and y holds.
- hsync, vsync, active and VGA_BLANK_N are registered decodes of the next x/y. They change on the same edge as x/y, with zero latency relative to the counters.
  - hsync is asserted for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (default 656..751).
  - vsync is asserted for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (default 490..491).
- line_start is high for exactly one clk, the cycle after the edge where x became 0. frame_start is the same, for the edge where x and y both became 0. Neither pulses after reset or resync; the first pulses occur at the first natural wrap.
- frame_cnt increments on the edge where y wraps V_TOTAL-1->0, modulo 256.
- en=0: div_cnt, x, y, vga_clk and frame_cnt hold. pix_ce=0, line_start=0, frame_start=0. On en re-assert, resume exactly where frozen.
- resync=1 on an edge, regardless of en: div_cnt=0, x=0, y=0, vga_clk=0, and decodes are loaded for (0,0). frame_cnt is unchanged and no strobes fire. resync has priority over counting.
- Reset (async, any time, including mid-frame) drives:
  - div_cnt=0, x=0, y=0, vga_clk=0, frame_cnt=0, line_start=0, frame_start=0.
  - active=1 and VGA_BLANK_N=1 (decode of 0,0).
  - hsync=~H_SYNC_POL and vsync=~V_SYNC_POL.
  - Counting starts on the first edge after release with en=1.
- No combinational path from en or resync to any output except pix_ce.

Test Plan:
- Reset and defaults, en=1. Hold rst low, then release.
  -> x=y=0, hsync=vsync=1, active=1, frame_cnt=0.
  -> pix_ce is high every 2nd clk.
  -> hsync low exactly for x=656..751; vsync low for y=490..491.
- Frame period, defaults. Run 2 frames.
  -> frame_start pulses are exactly 840000 clks apart.
  -> line_start pulses are 1600 clks apart.
  -> frame_cnt goes 0->1->2; active=0 at x=640 and at y=480.
- Freeze. Drop en for 37 clks at x=300.
  -> x, y and vga_clk are constant and pix_ce=0 throughout.
  -> After re-assert, x continues to 301 after the correct divider phase.
  -> frame period is lengthened by exactly 37 clks.
- Resync mid-frame. Pulse resync at (x=500, y=200).
  -> Next edge gives x=y=0, vga_clk=0, with no frame_start pulse and frame_cnt unchanged.
  -> The next frame_start occurs 840000 clks later.
- Small custom geometry. Set H=4/1/2/1, V=3/1/1/1, CLK_DIV=3, both POL=1.
  -> H_TOTAL=8, V_TOTAL=6, pix_ce every 3rd clk.
  -> hsync high for x=5..6; vsync high for y=4.
  -> vga_clk is low 1 clk and high 2 clks per pixel.
  -> frame period is 144 clks.
- Async reset mid-frame. Assert rst at (x=700, y=491) between edges.
  -> Outputs go to reset values immediately, with no strobes.
  -> Timing restarts cleanly from (0,0) after release.
